// File: rtl/uart_seq_tx_if.sv
// Trigger/payload and serial-side signals of the multi-character UART transmitter.
// The master drives start/payload; the transmitter (slave) drives the line and status.
interface uart_seq_tx_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NUM_CHARS = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_CHARS + 1);

    logic                           start;
    logic [NUM_CHARS*DATA_BITS-1:0] payload;
    logic                           tx;
    logic                           busy;
    logic                           done;
    logic [IDX_W-1:0]               char_idx;

    modport master (
        output start,
        output payload,
        input  tx,
        input  busy,
        input  done,
        input  char_idx
    );

    modport slave (
        input  start,
        input  payload,
        output tx,
        output busy,
        output done,
        output char_idx
    );
endinterface

// File: rtl/uart_seq_tx.sv
// Serialises NUM_CHARS back-to-back UART frames from a captured payload on a one-cycle
// trigger. Bit timing, parity, stop bits and the inter-character gap are parameters.
module uart_seq_tx #(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NUM_CHARS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned IDLE_GAP  = 0
) (
    input logic          clk,
    input logic          reset_n,
    uart_seq_tx_if.slave bus
);
    localparam int unsigned BAUD_P = CLK_HZ / BAUD;
    localparam int unsigned CNT_W  = (BAUD_P > 1) ? $clog2(BAUD_P) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned IDX_W  = $clog2(NUM_CHARS + 1);
    localparam int unsigned GAP_W  = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam int unsigned PAY_W  = NUM_CHARS * DATA_BITS;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_P - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHARS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StGap} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PAY_W-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               baud_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The whole payload shifts right one place per data bit, so the next character's LSB
    // is already at bit 0 when its frame starts.
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        shift_d  = shift_q;
        par_d    = par_q;
        baud_end = (baud_q == BAUD_LAST);
        baud_d   = baud_end ? '0 : baud_q + 1'b1;
        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (bus.start) begin
                    state_d = StStart;
                    shift_d = bus.payload;
                    idx_d   = '0;
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    par_d   = 1'b0;
                end
            end
            StData: begin
                if (baud_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (baud_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = StIdle;
                            idx_d   = '0;
                        end else if (IDLE_GAP > 0) begin
                            state_d = StGap;
                            gap_d   = '0;
                        end else begin
                            state_d = StStart;
                            idx_d   = idx_q + 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StGap: begin
                baud_d = '0;
                if (gap_q == GAP_LAST) begin
                    state_d = StStart;
                    idx_d   = idx_q + 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered line changes on the same
    // edge as the state it belongs to.
    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_q == StStop) && (state_d == StIdle);
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = (PARITY == 1) ? par_d : ~par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.char_idx = idx_q;
endmodule

// File: tb/tb_uart_seq_tx.sv
// Scoreboard bench for uart_seq_tx: stimulus queues expected characters and busy lengths,
// a line decoder and a done monitor pop and compare them.
module tb_uart_seq_tx;
    localparam int unsigned BP = 104;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_seq_tx_if #(.DATA_BITS(8), .NUM_CHARS(8)) ifa ();
    uart_seq_tx_if #(.DATA_BITS(8), .NUM_CHARS(2)) ifb ();
    uart_seq_tx_if #(.DATA_BITS(8), .NUM_CHARS(1)) ifc ();
    uart_seq_tx_if #(.DATA_BITS(9), .NUM_CHARS(2)) ifd ();

    uart_seq_tx #(
        .CLK_HZ(12000000), .BAUD(115200), .DATA_BITS(8), .NUM_CHARS(8),
        .PARITY(0), .STOP_BITS(1), .IDLE_GAP(0)
    ) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));

    uart_seq_tx #(
        .CLK_HZ(12000000), .BAUD(115200), .DATA_BITS(8), .NUM_CHARS(2),
        .PARITY(0), .STOP_BITS(2), .IDLE_GAP(50)
    ) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    uart_seq_tx #(
        .CLK_HZ(12000000), .BAUD(115200), .DATA_BITS(8), .NUM_CHARS(1),
        .PARITY(1), .STOP_BITS(1), .IDLE_GAP(0)
    ) dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

    uart_seq_tx #(
        .CLK_HZ(12000000), .BAUD(115200), .DATA_BITS(9), .NUM_CHARS(2),
        .PARITY(2), .STOP_BITS(1), .IDLE_GAP(0)
    ) dut_d (.clk(clk), .reset_n(reset_n), .bus(ifd));

    typedef struct {
        int data;
        int par;
        int idx;
        int gap;
    } exp_t;

    exp_t exp_q[$];
    int   busy_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   mon_sel = 0;
    bit   mon_en = 1'b0;
    int   cfg_db = 8;
    int   cfg_par = 0;
    int   cfg_stop = 1;

    logic       mon_tx, mon_busy, mon_done;
    logic [7:0] mon_idx;

    always_comb begin
        mon_tx   = ifa.tx;
        mon_busy = ifa.busy;
        mon_done = ifa.done;
        mon_idx  = 8'(ifa.char_idx);
        case (mon_sel)
            1: begin
                mon_tx = ifb.tx; mon_busy = ifb.busy; mon_done = ifb.done;
                mon_idx = 8'(ifb.char_idx);
            end
            2: begin
                mon_tx = ifc.tx; mon_busy = ifc.busy; mon_done = ifc.done;
                mon_idx = 8'(ifc.char_idx);
            end
            3: begin
                mon_tx = ifd.tx; mon_busy = ifd.busy; mon_done = ifd.done;
                mon_idx = 8'(ifd.char_idx);
            end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_char(input int data, input int par, input int idx, input int gap);
        exp_t e;
        e.data = data; e.par = par; e.idx = idx; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_a(input logic [7:0] ch [8], input int first_gap);
        for (int k = 0; k < 8; k++) push_char(int'(ch[k]), 0, k, (k == 0) ? first_gap : 0);
    endtask

    task automatic load_a(input logic [7:0] ch [8]);
        for (int k = 0; k < 8; k++) ifa.payload[k*8 +: 8] = ch[k];
    endtask

    // One-cycle start pulse; the line must already be low at the following sample.
    task automatic kick(input int sel);
        case (sel)
            1: ifb.start = 1'b1;
            2: ifc.start = 1'b1;
            3: ifd.start = 1'b1;
            default: ifa.start = 1'b1;
        endcase
        @(negedge clk);
        check("start_latency_tx", mon_tx, 0);
        check("start_busy", mon_busy, 1);
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; ifd.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy_q.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size() + busy_q.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    // Line decoder: every bit must hold its value for exactly BP samples.
    initial begin : decoder
        int         idle;
        int         nbits, idx_s, data, stopv;
        bit         ab, glitch;
        logic [15:0] fb;
        exp_t       e;
        idle = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                idle = 0;
            end else if (mon_tx === 1'b1) begin
                idle++;
            end else begin
                nbits  = 1 + cfg_db + ((cfg_par != 0) ? 1 : 0) + cfg_stop;
                idx_s  = int'(mon_idx);
                ab     = 1'b0;
                glitch = 1'b0;
                fb     = '0;
                for (int b = 0; b < nbits && !ab; b++) begin
                    for (int c = 0; c < BP && !ab; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!mon_en) ab = 1'b1;
                        else if (c == 0) fb[b] = mon_tx;
                        else if (mon_tx !== fb[b]) glitch = 1'b1;
                    end
                end
                if (!ab) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        data = 0;
                        for (int i = 0; i < cfg_db; i++) data |= int'(fb[1+i]) << i;
                        stopv = 0;
                        for (int j = 0; j < cfg_stop; j++) stopv |= int'(fb[nbits-cfg_stop+j]) << j;
                        check("char_data", data, e.data);
                        if (cfg_par != 0) check("parity_bit", fb[1+cfg_db], e.par);
                        check("stop_bits", stopv, (1 << cfg_stop) - 1);
                        check("bit_stable", glitch, 0);
                        check("char_idx", idx_s, e.idx);
                        if (e.gap >= 0) check("idle_gap", idle, e.gap);
                    end
                end
                idle = 0;
            end
        end
    end

    initial begin : busy_mon
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                cnt = 0;
            end else begin
                if (mon_busy === 1'b1) cnt++;
                if (mon_done === 1'b1) begin
                    done_cnt++;
                    check("done_busy_low", mon_busy, 0);
                    check("done_idx_zero", mon_idx, 0);
                    if (busy_q.size() == 0) check("unexpected_done", 1, 0);
                    else check("busy_cycles", cnt, busy_q.pop_front());
                    cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] ch_a [8];
        logic [7:0] ch_b [8];
        bit         stay;
        int         d0, n;
        ch_a = '{8'h55, 8'hA3, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h3C, 8'hC7};
        ch_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0; ifd.start = 1'b0;
        ifa.payload = '0; ifb.payload = '0; ifc.payload = '0; ifd.payload = '0;

        repeat (3) @(negedge clk);
        check("reset_tx", ifa.tx, 1);
        check("reset_busy", ifa.busy, 0);
        check("reset_done", ifa.done, 0);
        check("reset_idx", ifa.char_idx, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (3) @(negedge clk);

        // Full default sequence; a start pulse and payload change mid-way must be ignored.
        load_a(ch_a);
        push_a(ch_a, -1);
        busy_q.push_back(8320);
        kick(0);
        repeat (300) @(negedge clk);
        ifa.start = 1'b1;
        ifa.payload = ~ifa.payload;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_drain("seq_a_drain");
        check("done_once", done_cnt, 1);

        // Reset mid char 0 data, then a clean sequence from char 0.
        load_a(ch_a);
        kick(0);
        repeat (498) @(negedge clk);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_tx", ifa.tx, 1);
        check("async_reset_busy", ifa.busy, 0);
        check("async_reset_idx", ifa.char_idx, 0);
        repeat (5) @(negedge clk);
        exp_q.delete();
        busy_q.delete();
        reset_n = 1'b1;
        stay = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (ifa.tx !== 1'b1 || ifa.busy !== 1'b0) stay = 1'b1;
        end
        check("post_reset_idle", stay, 0);
        mon_en = 1'b1;
        load_a(ch_b);
        push_a(ch_b, -1);
        busy_q.push_back(8320);
        kick(0);
        wait_drain("seq_after_reset_drain");
        check("done_after_reset", done_cnt, 2);

        // start held high: two sequences separated only by the done cycle.
        load_a(ch_a);
        push_a(ch_a, -1);
        push_a(ch_a, 1);
        busy_q.push_back(8320);
        busy_q.push_back(8320);
        d0 = done_cnt;
        ifa.start = 1'b1;
        @(negedge clk);
        check("held_latency_tx", ifa.tx, 0);
        n = 0;
        while (done_cnt == d0 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("held_first_done", done_cnt, d0 + 1);
        repeat (100) @(negedge clk);
        ifa.start = 1'b0;
        wait_drain("held_drain");
        check("held_done_count", done_cnt, d0 + 2);

        // Two stop bits and a 50-cycle gap between characters.
        mon_sel  = 1;
        cfg_stop = 2;
        ifb.payload = {8'hC5, 8'h3A};
        push_char(8'h3A, 0, 0, -1);
        push_char(8'hC5, 0, 1, 50);
        busy_q.push_back(2338);
        kick(1);
        wait_drain("gap_drain");

        // Even parity, single character.
        mon_sel  = 2;
        cfg_stop = 1;
        cfg_par  = 1;
        ifc.payload = 8'h07;
        push_char(8'h07, 1, 0, -1);
        busy_q.push_back(1144);
        kick(2);
        wait_drain("even_drain");

        // Odd parity with 9-bit characters.
        mon_sel = 3;
        cfg_par = 2;
        cfg_db  = 9;
        ifd.payload = {9'h180, 9'h007};
        push_char(9'h007, 0, 0, -1);
        push_char(9'h180, 1, 1, 0);
        busy_q.push_back(2496);
        kick(3);
        wait_drain("odd9_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
